// File: rtl/tcp_ack_rx.sv
// tcp_ack_rx: passive tap on a 256-bit AXI-Stream packet bus. It parses the
// Ethernet/IPv4/TCP headers in the first two beats of each packet and
// reports every ACK segment of one configured connection, including a
// duplicate-ACK flag. Only C_S_AXIS_DATA_WIDTH = 256 is supported.
// Optional feature: define TCP_ACK_RX_STATS_EN to add the ack_count port
// (matched-ACK counter, wraps at 2^32).
module tcp_ack_rx #(
  parameter int C_S_AXIS_DATA_WIDTH = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [31:0]                      local_ip,
  input  logic [31:0]                      remote_ip,
  input  logic [15:0]                      local_port,
  input  logic [15:0]                      remote_port,
  output logic                             ack_valid,
  output logic                             dup_ack,
  output logic [31:0]                      ack_num,
  output logic [31:0]                      seq_num,
  output logic [15:0]                      ack_win,
  output logic [7:0]                       ack_flags,
  output logic [15:0]                      ack_payload_len
`ifdef TCP_ACK_RX_STATS_EN
  ,
  output logic [31:0]                      ack_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_SKIP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_accept;

  // Beat 1 fields (bytes 0-31, byte 0 in the top byte lane)
  logic [15:0] w_ethertype;
  logic [7:0]  w_ver_ihl;
  logic [15:0] w_total_len;
  logic [15:0] w_frag;
  logic [7:0]  w_proto;
  logic [31:0] w_src_ip;
  logic [15:0] w_dst_ip_hi;
  logic        w_hdr1_ok;

  // Beat 2 fields (bytes 32-63)
  logic [15:0] w_dst_ip_lo;
  logic [15:0] w_src_port;
  logic [15:0] w_dst_port;
  logic [31:0] w_seq;
  logic [31:0] w_ack;
  logic [3:0]  w_doff;
  logic [7:0]  w_flags;
  logic [15:0] w_win;
  logic [15:0] w_hdr_len;
  logic [15:0] w_payload_len;
  logic        w_hdr2_ok;
  logic        w_report;
  logic        w_dup;

  logic [15:0] r_total_len;
  logic [31:0] r_last_ack;
  logic [15:0] r_last_win;
  logic        r_last_valid;

  // Bits not inspected by any check; referenced here so the tap is explicit
  logic        w_unused;

  assign w_unused = ^{s_axis_tdata, s_axis_tkeep};

  assign w_accept = s_axis_tvalid & s_axis_tready;

  assign w_ethertype = s_axis_tdata[159:144];
  assign w_ver_ihl   = s_axis_tdata[143:136];
  assign w_total_len = s_axis_tdata[127:112];
  assign w_frag      = s_axis_tdata[95:80];
  assign w_proto     = s_axis_tdata[71:64];
  assign w_src_ip    = s_axis_tdata[47:16];
  assign w_dst_ip_hi = s_axis_tdata[15:0];

  assign w_hdr1_ok = (s_axis_tkeep == '1) && !s_axis_tlast &&
                     (w_ethertype == 16'h0800) &&
                     (w_ver_ihl == 8'h45) &&
                     (w_proto == 8'h06) &&
                     ((w_frag & 16'h3FFF) == 16'h0000) &&
                     (w_src_ip == remote_ip) &&
                     (w_dst_ip_hi == local_ip[31:16]);

  assign w_dst_ip_lo = s_axis_tdata[255:240];
  assign w_src_port  = s_axis_tdata[239:224];
  assign w_dst_port  = s_axis_tdata[223:208];
  assign w_seq       = s_axis_tdata[207:176];
  assign w_ack       = s_axis_tdata[175:144];
  assign w_doff      = s_axis_tdata[143:140];
  assign w_flags     = s_axis_tdata[135:128];
  assign w_win       = s_axis_tdata[127:112];

  // IP header is fixed at 20 bytes (IHL 5); TCP header is 4*doff bytes
  assign w_hdr_len     = 16'd20 + {10'd0, w_doff, 2'b00};
  assign w_payload_len = r_total_len - w_hdr_len;

  assign w_hdr2_ok = (s_axis_tkeep[31:10] == '1) &&
                     (w_dst_ip_lo == local_ip[15:0]) &&
                     (w_src_port == remote_port) &&
                     (w_dst_port == local_port) &&
                     w_flags[4] && !w_flags[2] &&
                     (r_total_len >= w_hdr_len);

  assign w_report = (r_state == ST_HDR2) && w_accept && w_hdr2_ok;

  assign w_dup = (w_flags == 8'h10) && (w_payload_len == 16'd0) &&
                 r_last_valid && (w_ack == r_last_ack) &&
                 (w_win == r_last_win);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: header beats are consumed only on a handshake
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hdr1_ok) begin
            w_state_nxt = ST_HDR2;
          end else if (s_axis_tlast) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_SKIP;
          end
        end
      end
      ST_HDR2: begin
        if (w_accept) begin
          w_state_nxt = s_axis_tlast ? ST_IDLE : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (w_accept && s_axis_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch IPv4 total length from the first beat of every packet
  always_ff @(posedge clk) begin
    if (reset) begin
      r_total_len <= '0;
    end else if ((r_state == ST_IDLE) && w_accept) begin
      r_total_len <= w_total_len;
    end
  end

  // Report registers: pulse valid/dup, hold data until the next report
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_valid       <= 1'b0;
      dup_ack         <= 1'b0;
      ack_num         <= '0;
      seq_num         <= '0;
      ack_win         <= '0;
      ack_flags       <= '0;
      ack_payload_len <= '0;
    end else begin
      ack_valid <= w_report;
      dup_ack   <= w_report && w_dup;
      if (w_report) begin
        ack_num         <= w_ack;
        seq_num         <= w_seq;
        ack_win         <= w_win;
        ack_flags       <= w_flags;
        ack_payload_len <= w_payload_len;
      end
    end
  end

  // Remember the last reported ACK for duplicate detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_ack   <= '0;
      r_last_win   <= '0;
      r_last_valid <= 1'b0;
    end else if (w_report) begin
      r_last_ack   <= w_ack;
      r_last_win   <= w_win;
      r_last_valid <= 1'b1;
    end
  end

`ifdef TCP_ACK_RX_STATS_EN
  // Matched-ACK counter, free-running wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_count <= '0;
    end else if (w_report) begin
      ack_count <= ack_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tcp_ack_rx.sv
// Scoreboard bench for tcp_ack_rx: packets are built byte-by-byte, expected
// reports are queued when beat 2 is driven and compared when ack_valid pulses.
module tb_tcp_ack_rx;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [31:0]  local_ip;
  logic [31:0]  remote_ip;
  logic [15:0]  local_port;
  logic [15:0]  remote_port;
  logic         ack_valid;
  logic         dup_ack;
  logic [31:0]  ack_num;
  logic [31:0]  seq_num;
  logic [15:0]  ack_win;
  logic [7:0]   ack_flags;
  logic [15:0]  ack_payload_len;
`ifdef TCP_ACK_RX_STATS_EN
  logic [31:0]  ack_count;
`endif

  always #5 clk = ~clk;

  tcp_ack_rx #(.C_S_AXIS_DATA_WIDTH(256)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axis_tdata    (tdata),
    .s_axis_tkeep    (tkeep),
    .s_axis_tvalid   (tvalid),
    .s_axis_tready   (tready),
    .s_axis_tlast    (tlast),
    .local_ip        (local_ip),
    .remote_ip       (remote_ip),
    .local_port      (local_port),
    .remote_port     (remote_port),
    .ack_valid       (ack_valid),
    .dup_ack         (dup_ack),
    .ack_num         (ack_num),
    .seq_num         (seq_num),
    .ack_win         (ack_win),
    .ack_flags       (ack_flags),
    .ack_payload_len (ack_payload_len)
`ifdef TCP_ACK_RX_STATS_EN
    ,
    .ack_count       (ack_count)
`endif
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] etype;
    logic [7:0]  verihl;
    logic [15:0] tot;
    logic [15:0] frag;
    logic [7:0]  proto;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [3:0]  doff;
    logic [7:0]  flags;
    logic [15:0] win;
    int          nbeats;
  } pkt_t;

  typedef struct {
    logic [31:0] ack;
    logic [31:0] seq;
    logic [15:0] win;
    logic [7:0]  flags;
    logic [15:0] len;
    logic        dup;
    logic [31:0] cnt;
    int unsigned at;
  } exp_t;

  exp_t q[$];

  // Reference model of the duplicate-ACK history and counter
  logic [31:0] m_last_ack;
  logic [15:0] m_last_win;
  bit          m_last_valid;
  logic [31:0] m_count;

  function automatic pkt_t base_pkt();
    pkt_t p;
    p.etype  = 16'h0800;
    p.verihl = 8'h45;
    p.tot    = 16'd52;
    p.frag   = 16'h4000;
    p.proto  = 8'h06;
    p.sip    = 32'h8C7452B9;
    p.dip    = 32'h8C7452BD;
    p.sp     = 16'h138A;
    p.dp     = 16'hE704;
    p.seq    = 32'h11223344;
    p.ack    = 32'hCF5254D4;
    p.doff   = 4'd8;
    p.flags  = 8'h10;
    p.win    = 16'h0073;
    p.nbeats = 2;
    return p;
  endfunction

  function automatic logic [255:0] beat_data(input pkt_t p, input int idx);
    logic [7:0]   b [0:95];
    logic [255:0] d;
    for (int i = 0; i < 96; i++) b[i] = 8'(i * 7 + 3);
    b[12] = p.etype[15:8];  b[13] = p.etype[7:0];
    b[14] = p.verihl;
    b[16] = p.tot[15:8];    b[17] = p.tot[7:0];
    b[20] = p.frag[15:8];   b[21] = p.frag[7:0];
    b[23] = p.proto;
    b[26] = p.sip[31:24];   b[27] = p.sip[23:16];
    b[28] = p.sip[15:8];    b[29] = p.sip[7:0];
    b[30] = p.dip[31:24];   b[31] = p.dip[23:16];
    b[32] = p.dip[15:8];    b[33] = p.dip[7:0];
    b[34] = p.sp[15:8];     b[35] = p.sp[7:0];
    b[36] = p.dp[15:8];     b[37] = p.dp[7:0];
    b[38] = p.seq[31:24];   b[39] = p.seq[23:16];
    b[40] = p.seq[15:8];    b[41] = p.seq[7:0];
    b[42] = p.ack[31:24];   b[43] = p.ack[23:16];
    b[44] = p.ack[15:8];    b[45] = p.ack[7:0];
    b[46] = {p.doff, 4'h0};
    b[47] = p.flags;
    b[48] = p.win[15:8];    b[49] = p.win[7:0];
    d = '0;
    for (int j = 0; j < 32; j++) d[255 - 8*j -: 8] = b[32*idx + j];
    return d;
  endfunction

  // Drive one beat; k is the cycle count at the negedge before its handshake
  task automatic beat(input logic [255:0] d, input bit last, input int stall, output int unsigned k);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      tdata = d; tkeep = '1; tvalid = 1'b1; tready = 1'b0; tlast = last;
    end
    @(negedge clk);
    tdata = d; tkeep = '1; tvalid = 1'b1; tready = 1'b1; tlast = last;
    k = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    end
  endtask

  task automatic push_exp(input pkt_t p, input int unsigned k);
    exp_t e;
    e.ack   = p.ack;
    e.seq   = p.seq;
    e.win   = p.win;
    e.flags = p.flags;
    e.len   = p.tot - 16'(20 + 4 * int'(p.doff));
    e.dup   = (p.flags == 8'h10) && (e.len == 16'd0) && m_last_valid &&
              (p.ack == m_last_ack) && (p.win == m_last_win);
    m_last_ack   = p.ack;
    m_last_win   = p.win;
    m_last_valid = 1'b1;
    m_count      = m_count + 32'd1;
    e.cnt = m_count;
    e.at  = k + 1;
    q.push_back(e);
  endtask

  task automatic send(input pkt_t p, input bit expect_rep, input int stall2);
    int unsigned k;
    for (int i = 0; i < p.nbeats; i++) begin
      beat(beat_data(p, i), (i == p.nbeats - 1), (i == 1) ? stall2 : 0, k);
      if (i == 1 && expect_rep) push_exp(p, k);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      if (ack_valid) begin
        if (q.size() == 0) begin
          check("spurious_ack", 32'(ack_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.at);
          check("ack_num", ack_num, e.ack);
          check("seq_num", seq_num, e.seq);
          check("ack_win", 32'(ack_win), 32'(e.win));
          check("ack_flags", 32'(ack_flags), 32'(e.flags));
          check("payload_len", 32'(ack_payload_len), 32'(e.len));
          check("dup_ack", 32'(dup_ack), 32'(e.dup));
`ifdef TCP_ACK_RX_STATS_EN
          check("ack_count", ack_count, e.cnt);
`endif
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        check("missing_ack", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(ack_valid), 32'd0);
    check({tag, "_dup"}, 32'(dup_ack), 32'd0);
    check({tag, "_ack"}, ack_num, 32'd0);
    check({tag, "_seq"}, seq_num, 32'd0);
    check({tag, "_win"}, 32'(ack_win), 32'd0);
    check({tag, "_flags"}, 32'(ack_flags), 32'd0);
    check({tag, "_len"}, 32'(ack_payload_len), 32'd0);
`ifdef TCP_ACK_RX_STATS_EN
    check({tag, "_count"}, ack_count, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    int unsigned k;
    reset = 1'b1;
    tdata = '0; tkeep = '0; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    local_ip = 32'h8C7452BD; remote_ip = 32'h8C7452B9;
    local_port = 16'hE704;   remote_port = 16'h138A;
    m_last_ack = '0; m_last_win = '0; m_last_valid = 1'b0; m_count = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(2);

    // Pure ACK, then a back-to-back duplicate, then a window update
    p = base_pkt();
    send(p, 1'b1, 0);
    send(p, 1'b1, 0);
    p.win = 16'h0080;
    send(p, 1'b1, 0);
    idle(3);

    // ACK+PSH with 112 payload bytes over 3 beats
    p = base_pkt();
    p.flags = 8'h18; p.tot = 16'd152; p.doff = 4'd5; p.nbeats = 3;
    send(p, 1'b1, 0);
    idle(3);

    // Mismatching packets, none reported
    p = base_pkt(); p.dp = 16'hE705;
    send(p, 1'b0, 0); idle(1);
    p = base_pkt(); p.etype = 16'h86DD;
    send(p, 1'b0, 0); idle(1);
    p = base_pkt(); p.flags = 8'h14;
    send(p, 1'b0, 0); idle(1);
    p = base_pkt(); p.tot = 16'd30;
    send(p, 1'b0, 0); idle(1);
    p = base_pkt(); p.nbeats = 3; p.sip = 32'h8C7452BA;
    send(p, 1'b0, 0);
    // A clean packet right after the rejects proves the FSM is back in IDLE
    p = base_pkt();
    send(p, 1'b1, 0);
    idle(3);

    // Beat 2 held off by tready for 3 cycles
    p = base_pkt(); p.ack = 32'hCF525500; p.seq = 32'h11223400;
    send(p, 1'b1, 3);
    idle(3);

    // Packet ending on beat 1 is dropped; next packet still parsed
    p = base_pkt();
    beat(beat_data(p, 0), 1'b1, 0, k);
    p.ack = 32'hCF525600;
    send(p, 1'b1, 0);
    idle(3);

    // Reset while in HDR2, then the tail arrives as a new packet
    p = base_pkt();
    beat(beat_data(p, 0), 1'b0, 0, k);
    @(negedge clk);
    tvalid = 1'b0; reset = 1'b1;
    m_last_valid = 1'b0; m_last_ack = '0; m_last_win = '0; m_count = '0;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    beat(beat_data(p, 1), 1'b1, 0, k);
    send(p, 1'b1, 0);
    idle(6);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_ack_rx.md
# tcp_ack_rx

Receive-side companion to the TCP ACK packet builder in the router output-port-lookup path. It passively taps a 256-bit AXI-Stream packet bus and parses Ethernet/IPv4/TCP headers from the first two beats of each packet. It matches packets against one configured TCP connection and reports every segment with ACK set: acknowledgement number, sequence number, window, flags and payload length, plus a duplicate-ACK indication. The connection-state logic uses these reports to advance its send window and to decide when to fire the ACK builder.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, stream width; only 256 is supported.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_axis_tdata  in  256  packet data; byte 0 in [255:248], byte 31 in [7:0].
- s_axis_tkeep  in  32  byte enables, MSB-aligned; bit 31 qualifies byte 0.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  in  1  downstream ready. Observed only; a beat is accepted when tvalid && tready.
- s_axis_tlast  in  1  last beat of packet.
- local_ip  in  32  our IPv4 address; must equal the packet's dst IP.
- remote_ip  in  32  peer IPv4 address; must equal the packet's src IP.
- local_port  in  16  must equal the TCP dst port.
- remote_port  in  16  must equal the TCP src port.
- ack_valid  out  1  one-cycle pulse per matched ACK segment.
- dup_ack  out  1  qualifies ack_valid; the segment is a duplicate ACK.
- ack_num  out  32  TCP acknowledgement number.
- seq_num  out  32  TCP sequence number.
- ack_win  out  16  TCP window.
- ack_flags  out  8  TCP flags byte.
- ack_payload_len  out  16  TCP payload bytes.
- ack_count  out  32  matched-ACK counter; present only with TCP_ACK_RX_STATS_EN.

## Operation
- Beat 1 holds bytes 0–31 and beat 2 holds bytes 32–63. Fields are big-endian.
- Beat 1 must satisfy all of the following:
  - tkeep = 0xFFFFFFFF and tlast = 0.
  - ethertype (bytes 12–13) = 0x0800.
  - byte 14 = 0x45 (IHL 5 only; IP options are rejected).
  - protocol (byte 23) = 0x06.
  - (bytes 20–21 & 0x3FFF) = 0, i.e. unfragmented.
  - src IP (bytes 26–29) = remote_ip.
  - bytes 30–31 = local_ip[31:16].
- Beat 1 also latches total_len (bytes 16–17).
- Beat 2 must satisfy all of the following:
  - tkeep[31:10] all ones (bytes 32–53 present).
  - bytes 32–33 = local_ip[15:0].
  - src port (bytes 34–35) = remote_port.
  - dst port (bytes 36–37) = local_port.
  - ACK flag (byte 47 bit 4) = 1 and RST (bit 2) = 0.
  - total_len ≥ 20 + 4·doff, where doff = byte 46[7:4].
- Beat 2 fields: seq = bytes 38–41, ack = bytes 42–45, window = bytes 48–49.
- ack_payload_len = total_len − 20 − 4·doff, computed at 16 bits. The underflow case is rejected before subtraction.
- dup_ack = 1 only when all of the following hold:
  - flags = 0x10 and payload_len = 0;
  - ack_num and ack_win equal the last reported ACK;
  - a last ACK exists (last_valid set).
- Every reported ACK updates last_ack, last_win and last_valid.
- State machine:
  - IDLE: on an accepted beat, go to HDR2 if beat 1 passes and tlast = 0; otherwise go to SKIP, or stay in IDLE if tlast = 1.
  - HDR2: on an accepted beat, evaluate beat 2. Report on pass. Then go to IDLE if tlast = 1, else SKIP.
  - SKIP: stay until an accepted beat with tlast = 1, then go to IDLE.
- Beats with tvalid && !tready are ignored in all states.

## Timing
- Reset values: state IDLE; ack_valid 0; dup_ack 0; ack_num, seq_num, ack_flags, ack_win, ack_payload_len 0; ack_count 0; last_valid 0.
- ack_valid and dup_ack assert exactly one cycle after the beat-2 handshake, for one cycle.
- Data outputs update in that same cycle and hold until the next report.
- Back-to-back minimum packets (2 beats, tlast on beat 2) produce one report per packet with no dead cycle; IDLE accepts the next beat immediately.
- A 2-beat packet that ends on beat 2 is legal.
- A packet that ends on beat 1 is dropped, and the module returns to IDLE.
- Configuration inputs are sampled at the beat being checked. Changing them mid-packet affects only checks not yet performed.
- Reset mid-packet forces IDLE. The remainder of the interrupted packet is parsed as a new packet and fails the header checks, except by coincidence.
- ack_count wraps from 0xFFFFFFFF to 0.

## Configuration
- TCP_ACK_RX_STATS_EN defined: the ack_count port exists and increments by 1 in the cycle ack_valid asserts.
- TCP_ACK_RX_STATS_EN undefined: the ack_count port and its counter are absent. All other behaviour is identical.

## Test plan
Common config: local_ip 0x8C7452BD, remote_ip 0x8C7452B9, local_port 0xE704, remote_port 0x138A.
- Pure ACK with src 0x8C7452B9:0x138A, dst 0x8C7452BD:0xE704, seq 0x11223344, ack 0xCF5254D4, flags 0x10, win 0x0073, doff 8, total_len 52 -> one cycle after beat 2: ack_valid = 1, dup_ack = 0, payload_len 0; ack_count = 1 when stats are enabled.
- The same packet repeated back-to-back -> second report has dup_ack = 1; a third copy with win 0x0080 -> dup_ack = 0.
- ACK+PSH (flags 0x18), total_len 152, doff 5, 3 beats -> ack_payload_len = 112; the third beat is skipped in SKIP.
- Mismatches, each sent separately -> no ack_valid, and the state returns to IDLE after tlast:
  - dst port 0xE705;
  - ethertype 0x86DD;
  - RST set (flags 0x14);
  - total_len 30 with doff 8.
- Beat 2 presented with tready = 0 for 3 cycles, then accepted -> ack_valid asserts exactly one cycle after acceptance.
- Reset asserted while in HDR2, then a valid ACK packet is sent -> the first beat after reset is parsed as a new packet, and the clean packet is reported normally.
